// File: rtl/uart_frac_baud_gen_pkg.sv
// Shared widths, baud constants for a 100 MHz system clock, and the divisor record.
package uart_pkg;
  localparam int UART_DIV_W  = 16;
  localparam int UART_FRAC_W = 4;
  localparam int UART_OSR    = 16;

  localparam int UART_CLK_HZ = 100_000_000;

  // 100e6 / (baud * 16): integer part and nearest 1/16 remainder
  localparam int BAUD_9600_INT    = 651;
  localparam int BAUD_9600_FRAC   = 1;
  localparam int BAUD_115200_INT  = 54;
  localparam int BAUD_115200_FRAC = 4;

  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } div_t;

  localparam div_t BAUD_9600   = '{div_int: UART_DIV_W'(BAUD_9600_INT),
                                   div_frac: UART_FRAC_W'(BAUD_9600_FRAC)};
  localparam div_t BAUD_115200 = '{div_int: UART_DIV_W'(BAUD_115200_INT),
                                   div_frac: UART_FRAC_W'(BAUD_115200_FRAC)};
endpackage

// File: rtl/uart_frac_baud_gen_if.sv
// Control and tick bundle between the UART datapath (master) and the baud generator (slave).
interface uart_frac_baud_gen_if
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W
);
  logic              en;
  logic              div_wr;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              sync;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic              bclk;
  logic              upd_pend;

  modport master (
    output en, div_wr, div_int, div_frac, sync,
    input  os_tick, bit_tick, mid_tick, bclk, upd_pend
  );

  modport slave (
    input  en, div_wr, div_int, div_frac, sync,
    output os_tick, bit_tick, mid_tick, bclk, upd_pend
  );
endinterface

// File: rtl/uart_frac_baud_gen_frac_div.sv
// Fractional clock divider: period = max(div_int,2) + carry of the fractional accumulator.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              wrap,
  output logic              os_tick
);
  localparam logic [DIV_W:0] MIN_P = (DIV_W+1)'(2);

  logic [DIV_W:0]  cnt;
  logic [DIV_W:0]  int_eff;
  logic [DIV_W:0]  period;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_sum;
  logic              carry;

  // >= rather than == so a divisor shrunk while frozen cannot strand cnt above the period
  always_comb begin
    int_eff          = (div_int < DIV_W'(2)) ? MIN_P : {1'b0, div_int};
    {carry, acc_sum} = {1'b0, acc} + {1'b0, div_frac};
    period           = int_eff + (DIV_W+1)'(carry);
    wrap             = en && !clr && (cnt >= period - (DIV_W+1)'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      os_tick <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      acc     <= '0;
      os_tick <= 1'b0;
    end else begin
      os_tick <= wrap;
      if (wrap) begin
        cnt <= '0;
        acc <= acc_sum;
      end else if (en) begin
        cnt <= cnt + (DIV_W+1)'(1);
      end
    end
  end
endmodule

// File: rtl/uart_frac_baud_gen.sv
// Baud-tick generator top: shadowed divisor reload, bit phase counter, tick decode and bclk.
module uart_frac_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W        = UART_DIV_W,
  parameter int FRAC_W       = UART_FRAC_W,
  parameter int OSR          = UART_OSR,
  parameter int DEFAULT_INT  = BAUD_9600_INT,
  parameter int DEFAULT_FRAC = BAUD_9600_FRAC
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_frac_baud_gen_if.slave   bus
);
  localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;

  typedef struct packed {
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } cfg_t;

  cfg_t            active;
  cfg_t            shadow;
  cfg_t            wr_val;
  logic            pend;
  logic            apply;
  logic            wrap;
  logic            os_q;
  logic            bit_q;
  logic            mid_q;
  logic            bclk_q;
  logic [PH_W-1:0] ph;
  logic            ph_last;
  logic            ph_mid;

  assign wr_val  = '{div_int: bus.div_int, div_frac: bus.div_frac};
  assign ph_last = (ph == PH_W'(OSR - 1));
  assign ph_mid  = (ph == PH_W'(OSR / 2 - 1));
  // Running generator only swaps divisors on a bit boundary; a frozen one swaps at once
  assign apply   = pend && (!bus.en || (wrap && ph_last));

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .clr      (bus.sync),
    .div_int  (active.div_int),
    .div_frac (active.div_frac),
    .wrap     (wrap),
    .os_tick  (os_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '{div_int: DIV_W'(DEFAULT_INT), div_frac: FRAC_W'(DEFAULT_FRAC)};
      shadow <= '0;
      pend   <= 1'b0;
    end else if (bus.sync) begin
      if (bus.div_wr) begin
        active <= wr_val;
        shadow <= wr_val;
      end else if (pend) begin
        active <= shadow;
      end
      pend <= 1'b0;
    end else begin
      if (apply) active <= shadow;
      if (bus.div_wr) begin
        shadow <= wr_val;
        pend   <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= '0;
      bit_q  <= 1'b0;
      mid_q  <= 1'b0;
      bclk_q <= 1'b0;
    end else if (bus.sync) begin
      ph     <= '0;
      bit_q  <= 1'b0;
      mid_q  <= 1'b0;
      bclk_q <= 1'b0;
    end else begin
      bit_q <= wrap && ph_last;
      mid_q <= wrap && ph_mid;
      if (wrap) begin
        ph <= ph_last ? '0 : ph + PH_W'(1);
        if (ph_last)     bclk_q <= 1'b1;
        else if (ph_mid) bclk_q <= 1'b0;
      end
    end
  end

  assign bus.os_tick  = os_q;
  assign bus.bit_tick = bit_q;
  assign bus.mid_tick = mid_q;
  assign bus.bclk     = bclk_q;
  assign bus.upd_pend = pend;
endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Bench for uart_frac_baud_gen: directed timing scenarios plus random control traffic vs. a reference model.
module tb_uart_frac_baud_gen;
  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OSR      = 4;
  localparam int DEF_INT  = 7;
  localparam int DEF_FRAC = 3;
  localparam int FRAC_MOD = 1 << FRAC_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  uart_frac_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus_if ();

  uart_frac_baud_gen #(
    .DIV_W        (DIV_W),
    .FRAC_W       (FRAC_W),
    .OSR          (OSR),
    .DEFAULT_INT  (DEF_INT),
    .DEFAULT_FRAC (DEF_FRAC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  // Reference: elapsed edges in the current os period, global os-tick index within the bit,
  // fractional phase as plain modular arithmetic.
  int m_int, m_frac, s_int, s_frac, m_el, m_acc, m_n;
  bit m_pend, m_bclk, m_os, m_bit, m_mid;

  task automatic model_reset();
    m_int = DEF_INT; m_frac = DEF_FRAC; s_int = 0; s_frac = 0;
    m_el = 0; m_acc = 0; m_n = 0;
    m_pend = 0; m_bclk = 0; m_os = 0; m_bit = 0; m_mid = 0;
  endtask

  task automatic model_edge();
    int p;
    bit tick, app, at_end, at_mid;
    if (rst) begin
      model_reset();
      return;
    end
    if (bus_if.sync) begin
      if (bus_if.div_wr) begin
        m_int = int'(bus_if.div_int); m_frac = int'(bus_if.div_frac);
        s_int = m_int; s_frac = m_frac;
      end else if (m_pend) begin
        m_int = s_int; m_frac = s_frac;
      end
      m_pend = 0; m_el = 0; m_acc = 0; m_n = 0; m_bclk = 0;
      m_os = 0; m_bit = 0; m_mid = 0;
    end else begin
      p      = ((m_int < 2) ? 2 : m_int) + (((m_acc + m_frac) >= FRAC_MOD) ? 1 : 0);
      tick   = bus_if.en && (m_el + 1 >= p);
      at_end = (m_n == OSR - 1);
      at_mid = (m_n == OSR / 2 - 1);
      app    = m_pend && (!bus_if.en || (tick && at_end));
      m_os = tick; m_bit = tick && at_end; m_mid = tick && at_mid;
      if (tick) begin
        m_el  = 0;
        m_acc = (m_acc + m_frac) % FRAC_MOD;
        if (at_end) m_bclk = 1;
        else if (at_mid) m_bclk = 0;
        m_n = (m_n + 1) % OSR;
      end else if (bus_if.en) begin
        m_el++;
      end
      if (app) begin m_int = s_int; m_frac = s_frac; end
      if (bus_if.div_wr) begin
        s_int = int'(bus_if.div_int); s_frac = int'(bus_if.div_frac); m_pend = 1;
      end else if (app) begin
        m_pend = 0;
      end
    end
  endtask

  function automatic int obs_vec();
    return int'({bus_if.os_tick, bus_if.bit_tick, bus_if.mid_tick, bus_if.bclk, bus_if.upd_pend});
  endfunction

  function automatic int exp_vec();
    return int'({m_os, m_bit, m_mid, m_bclk, m_pend});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle{os,bit,mid,bclk,pend}", obs_vec(), exp_vec());
    bus_if.div_wr = 1'b0;
    bus_if.sync   = 1'b0;
  endtask

  function automatic bit tick_of(input int which);
    case (which)
      0:       return bus_if.os_tick;
      1:       return bus_if.bit_tick;
      default: return bus_if.mid_tick;
    endcase
  endfunction

  // Steps until the chosen tick (0 os, 1 bit, 2 mid) is seen; -1 if the budget runs out.
  task automatic run_until(input int which, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      n++;
      if (tick_of(which)) return;
    end
    n = -1;
  endtask

  task automatic load_sync(input int di, input int df);
    bus_if.div_wr   = 1'b1;
    bus_if.sync     = 1'b1;
    bus_if.div_int  = DIV_W'(di);
    bus_if.div_frac = FRAC_W'(df);
    step();
  endtask

  initial begin
    int n, ticks, highs, k;
    int per[16];

    bus_if.en = 1'b1; bus_if.div_wr = 1'b0; bus_if.sync = 1'b0;
    bus_if.div_int = '0; bus_if.div_frac = '0;
    model_reset();
    #1;
    chk("reset_outputs", obs_vec(), 0);
    step(); step();
    rst = 1'b0;
    run_until(0, 50, n);
    chk("first_os_after_reset", n, DEF_INT);

    // OSR=4, div 4.0: tick spacing and bclk duty
    load_sync(4, 0);
    run_until(0, 20, n);  chk("os_period_4", n, 4);
    run_until(1, 40, n);  chk("first_bit_tick", n, 12);
    chk("bclk_set_on_bit", int'(bus_if.bclk), 1);
    run_until(2, 40, n);  chk("bit_to_mid", n, 8);
    chk("bclk_clr_on_mid", int'(bus_if.bclk), 0);
    highs = 0;
    for (int i = 0; i < 16; i++) begin step(); highs += int'(bus_if.bclk); end
    chk("bclk_high_count", highs, 8);

    // div 4 + 4/16: one long period in four
    load_sync(4, 4);
    n = 0; k = 0;
    for (int i = 0; i < 16; i++) per[i] = 0;
    for (int i = 0; i < 200 && k < 16; i++) begin
      step();
      n++;
      per[k]++;
      if (bus_if.os_tick) k++;
    end
    chk("frac_16_periods_total", n, 68);
    chk("frac_period0", per[0], 4);
    chk("frac_period3", per[3], 5);

    // reload while running: waits for the bit boundary
    load_sync(4, 0);
    repeat (6) step();
    bus_if.div_wr = 1'b1; bus_if.div_int = DIV_W'(6); bus_if.div_frac = '0;
    step();
    chk("upd_pend_set", int'(bus_if.upd_pend), 1);
    run_until(1, 40, n);  chk("bit_tick_old_period", n, 9);
    chk("upd_pend_clear", int'(bus_if.upd_pend), 0);
    run_until(0, 20, n);  chk("new_period_6", n, 6);

    // sync lands on the edge a mid tick was due; it must be swallowed
    repeat (5) step();
    chk("bclk_high_before_sync", int'(bus_if.bclk), 1);
    bus_if.sync = 1'b1;
    step();
    chk("no_tick_on_sync", int'({bus_if.os_tick, bus_if.bit_tick, bus_if.mid_tick}), 0);
    chk("bclk_cleared_by_sync", int'(bus_if.bclk), 0);
    run_until(0, 20, n);  chk("os_after_sync", n, 6);
    run_until(2, 40, n);  chk("mid_after_sync", n, 6);
    chk("bclk_low_first_bit", int'(bus_if.bclk), 0);
    run_until(1, 40, n);  chk("bit_after_sync", n, 12);
    chk("bclk_high_after_bit", int'(bus_if.bclk), 1);

    // clamp of tiny divisors
    load_sync(0, 0);
    run_until(0, 20, n);  chk("clamp_div0_a", n, 2);
    run_until(0, 20, n);  chk("clamp_div0_b", n, 2);
    load_sync(1, 0);
    run_until(0, 20, n);  chk("clamp_div1_a", n, 2);
    run_until(0, 20, n);  chk("clamp_div1_b", n, 2);

    // freeze mid-period and resume
    load_sync(6, 0);
    step(); step();
    bus_if.en = 1'b0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      ticks += int'(bus_if.os_tick) + int'(bus_if.bit_tick) + int'(bus_if.mid_tick);
    end
    chk("no_ticks_while_frozen", ticks, 0);
    bus_if.en = 1'b1;
    run_until(0, 20, n);  chk("resume_remaining", n, 4);

    // asynchronous reset between edges while bclk is high
    load_sync(4, 0);
    run_until(1, 40, n);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", obs_vec(), 0);
    model_reset();
    step();
    rst = 1'b0;
    run_until(0, 50, n);  chk("first_os_after_rerelease", n, DEF_INT);

    // random control traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus_if.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        bus_if.div_wr   = 1'b1;
        bus_if.div_int  = DIV_W'($urandom_range(0, 9));
        bus_if.div_frac = FRAC_W'($urandom_range(0, FRAC_MOD - 1));
      end
      if ($urandom_range(0, 49) == 0) bus_if.sync = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
